fir_mac: RTL
============

FIR_MAC -- requirements
Module: fir_mac

Interface
REQ-001 Parameter: data_width, default 8, sample and coefficient width in bits.
REQ-002 Port: clock  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: x_in  in  data_width  unsigned input sample.
REQ-005 Port: valid_in  in  1  x_in valid.
REQ-006 Port: ready  out  1  block can accept a sample.
REQ-007 Port: mem_en  out  1  delay-line enable.
REQ-008 Port: mem_we  out  1  delay-line write/shift strobe.
REQ-009 Port: mem_addr  out  3  delay-line tap address.
REQ-010 Port: mem_di  out  data_width  sample written into the delay line.
REQ-011 Port: mem_dio  in  data_width  tap data from the delay line.
REQ-012 Port: y  out  2*data_width+3  unsigned filter output.
REQ-013 Port: valid_out  out  1  single-cycle pulse; y is valid.

Function
REQ-014 The delay line shifts on an enabled write edge with the newest sample at address 0, and returns ram[addr] on mem_dio one edge after an enabled read.
REQ-015 Coefficients are fixed constants h[0..7] = 1,2,3,4,4,3,2,1, unsigned, data_width bits each.
REQ-016 FSM states: IDLE, WRITE, READ, DRAIN.
REQ-017 ready is 1 only in IDLE; a sample is accepted on an edge where valid_in=1 and ready=1 (E0), x_in is captured, and the state becomes WRITE.
REQ-018 In IDLE with valid_in=0, the FSM stays in IDLE.
REQ-019 In WRITE: mem_en=1, mem_we=1, mem_di = captured sample, accumulator cleared at E1, next state READ with tap counter k=0.
REQ-020 In READ: mem_en=1, mem_we=0, mem_addr=k; k increments each edge; after k=7 is issued, next state DRAIN.
REQ-021 Each edge from E3 to E10 adds mem_dio*h[k-1] to the accumulator, using the tap index from one cycle earlier.
REQ-022 DRAIN lasts one cycle with mem_en=0; at its closing edge (E10), y <= final sum, valid_out <= 1, and the state becomes IDLE.
REQ-023 valid_out is 1 for exactly the cycle following E10 and returns to 0 at E11; y holds its value until the next result.
REQ-024 Latency from the accept edge to valid_out high is 10 edges; the next sample can be accepted at E11 at the earliest (1 sample per 11 cycles).
REQ-025 valid_in asserted while ready=0 is ignored, with no capture and no state change.
REQ-026 In IDLE, mem_en=0, mem_we=0, mem_addr=0, and mem_di=0.
REQ-027 Arithmetic is unsigned: each product is 2*data_width bits, the accumulator is 2*data_width+3 bits, and no overflow is possible.

Reset
REQ-028 reset=1 immediately forces: state IDLE, k=0, accumulator=0, y=0, valid_out=0, ready=1, mem_en=0, mem_we=0, mem_addr=0, mem_di=0.
REQ-029 Reset mid-operation (any state) abandons the computation without emitting a valid_out pulse; the delay line is cleared by the same reset.
REQ-030 After reset deasserts, the first edge with valid_in=1 is accepted normally.

Verification
REQ-031 Impulse: samples 1,0,0,0,0,0,0,0,0 (data_width=8) -> y sequence 1,2,3,4,4,3,2,1,0, one valid_out per sample.
REQ-032 Full scale: nine samples of 255 -> y = 255,765,1530,2550,3570,4335,4845,5100,5100, with no overflow.
REQ-033 Timing: accept at E0 -> mem_we=1 in the cycle after E0 only, mem_addr 0..7 in the following 8 cycles, valid_out high only after E10, and ready=0 from E0 to E10.
REQ-034 Busy: valid_in held at 1 with changing x_in during READ -> only the sample present at the accept edge enters the delay line; the next acceptance occurs at E11.
REQ-035 Reset mid-READ (k=4) -> all outputs take their reset values asynchronously, no valid_out follows, and the next impulse reproduces the REQ-031 sequence from y=1.

Source files
------------

// File: rtl/fir_mac.sv
// 8-tap symmetric FIR, one multiply-accumulate per cycle against an external
// shift-register delay line. Accepts one sample every 11 cycles.
module fir_mac #(
   parameter int data_width = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [data_width-1:0]     x_in,
   input  logic                      valid_in,
   output logic                      ready,
   output logic                      mem_en,
   output logic                      mem_we,
   output logic [2:0]                mem_addr,
   output logic [data_width-1:0]     mem_di,
   input  logic [data_width-1:0]     mem_dio,
   output logic [2*data_width+2:0]   y,
   output logic                      valid_out
);

   localparam int PW = 2*data_width;
   localparam int AW = 2*data_width+3;

   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

   state_t            state;
   logic [3:0]        k;
   logic [AW-1:0]     acc;
   logic [2:0]        tap;
   logic [data_width-1:0] coef;
   logic [PW-1:0]     prod;
   logic [AW-1:0]     sum;

   // Read data arrives one edge after the address, so weight it with the
   // previous tap index; k=8 wraps to tap 7 for the final add in DRAIN.
   always_comb begin
      tap  = k[2:0] - 3'd1;
      coef = data_width'(1);
      case (tap)
         3'd0, 3'd7: coef = data_width'(1);
         3'd1, 3'd6: coef = data_width'(2);
         3'd2, 3'd5: coef = data_width'(3);
         default:    coef = data_width'(4);
      endcase
      prod = PW'(mem_dio) * PW'(coef);
      sum  = acc + AW'(prod);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         k         <= '0;
         acc       <= '0;
         y         <= '0;
         valid_out <= 1'b0;
         ready     <= 1'b1;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_di    <= '0;
      end else begin
         valid_out <= 1'b0;
         case (state)
            IDLE: begin
               if (valid_in) begin
                  mem_di <= x_in;
                  mem_en <= 1'b1;
                  mem_we <= 1'b1;
                  ready  <= 1'b0;
                  state  <= WRITE;
               end
            end
            WRITE: begin
               acc      <= '0;
               k        <= '0;
               mem_we   <= 1'b0;
               mem_addr <= '0;
               mem_di   <= '0;
               state    <= READ;
            end
            READ: begin
               if (k != 4'd0) acc <= sum;
               if (k[2:0] == 3'd7) begin
                  k        <= 4'd8;
                  mem_en   <= 1'b0;
                  mem_addr <= '0;
                  state    <= DRAIN;
               end else begin
                  k        <= k + 4'd1;
                  mem_addr <= k[2:0] + 3'd1;
               end
            end
            DRAIN: begin
               y         <= sum;
               valid_out <= 1'b1;
               k         <= '0;
               ready     <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
